// File: rtl/renode_pkg.sv
// Shared types for the Renode co-simulation message interface.
package renode_pkg;

    typedef logic [63:0] address_t;
    typedef logic [63:0] data_t;

    typedef enum logic [7:0] {
        ACTION_INVALID           = 8'd0,
        ACTION_TICK_CLOCK        = 8'd1,
        ACTION_WRITE_REQUEST     = 8'd2,
        ACTION_READ_REQUEST      = 8'd3,
        ACTION_RESET_PERIPHERAL  = 8'd4,
        ACTION_LOG_MESSAGE       = 8'd5,
        ACTION_INTERRUPT         = 8'd6,
        ACTION_OK                = 8'd7,
        ACTION_ERROR             = 8'd8
    } action_e;

    typedef struct packed {
        action_e  action;
        address_t address;
        data_t    data;
    } message_t;

    // Index width for a vector of count entries; never narrower than one bit.
    function automatic int index_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/renode_gpio_priority_pick.sv
// Lowest-set-bit encoder: returns the index of the lowest asserted bit and whether any bit is set.
module renode_gpio_priority_pick #(
    parameter int Width      = 1,
    parameter int IndexWidth = 1
) (
    input  logic [Width-1:0]      vec,
    output logic [IndexWidth-1:0] index,
    output logic                  found
);

    // Scanning downwards lets the lowest set bit be the last one written.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IndexWidth'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/renode_gpio_input_reporter.sv
// Reports each GPIO level change to Renode as one interrupt message (index, new level).
// Define INPUTS_SYNC_EN to add a two-flop synchronizer for asynchronous GPIO sources.
module renode_gpio_input_reporter
    import renode_pkg::*;
#(
    parameter int InputsCount = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [InputsCount-1:0] inputs,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output address_t               msg_address,
    output data_t                  msg_data,
    output action_e                msg_action,
    output logic                   pending
);

    localparam int IndexWidth = index_width(InputsCount);

    logic [InputsCount-1:0] sample_src;
    logic [InputsCount-1:0] sampled;
    logic [InputsCount-1:0] reported;
    logic [InputsCount-1:0] diff;
    logic [IndexWidth-1:0]  pick_index;
    logic                   pick_found;
    logic                   load;
    message_t               next_msg;

`ifdef INPUTS_SYNC_EN
    logic [InputsCount-1:0] sync_meta;
    logic [InputsCount-1:0] sync_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= inputs;
            sync_out  <= sync_meta;
        end
    end

    assign sample_src = sync_out;
`else
    assign sample_src = inputs;
`endif

    // Bits still owed to Renode; the in-flight index is already excluded.
    assign diff    = sampled ^ reported;
    assign pending = |diff;

    renode_gpio_priority_pick #(
        .Width      (InputsCount),
        .IndexWidth (IndexWidth)
    ) u_pick (
        .vec   (diff),
        .index (pick_index),
        .found (pick_found)
    );

    // A new message may load when the output slot is empty or being handed off.
    assign load = pick_found && (!msg_valid || msg_ready);

    always_comb begin
        next_msg.action  = ACTION_INTERRUPT;
        next_msg.address = address_t'(pick_index);
        next_msg.data    = data_t'(sampled[pick_index]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sampled     <= '0;
            reported    <= '0;
            msg_valid   <= 1'b0;
            msg_address <= '0;
            msg_data    <= '0;
        end else begin
            sampled <= sample_src;
            if (load) begin
                msg_valid            <= 1'b1;
                msg_address          <= next_msg.address;
                msg_data             <= next_msg.data;
                reported[pick_index] <= sampled[pick_index];
            end else if (msg_ready) begin
                msg_valid <= 1'b0;
            end
        end
    end

    assign msg_action = ACTION_INTERRUPT;

endmodule

// File: tb/tb_renode_gpio_input_reporter.sv
// Self-checking bench for renode_gpio_input_reporter (InputsCount=4) against a message-level reference model.
module tb_renode_gpio_input_reporter;
    import renode_pkg::*;

    localparam int N = 4;
`ifdef INPUTS_SYNC_EN
    localparam int DELAY_STAGES = 2;
`else
    localparam int DELAY_STAGES = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] in_r = '0;
    logic         ready = 1'b1;
    logic         msg_valid;
    address_t     msg_address;
    data_t        msg_data;
    action_e      msg_action;
    logic         pending;

    int n_vec = 0;
    int n_err = 0;

    renode_gpio_input_reporter #(.InputsCount(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inputs      (in_r),
        .msg_valid   (msg_valid),
        .msg_ready   (ready),
        .msg_address (msg_address),
        .msg_data    (msg_data),
        .msg_action  (msg_action),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    // Reference model: what Renode has been told, what is on the wire, and a delay line for input capture.
    logic [N-1:0] m_sampled;
    logic [N-1:0] m_sent;
    logic [N-1:0] m_dl[$];
    bit           m_valid;
    int           m_addr;
    bit           m_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sampled = '0;
        m_sent    = '0;
        m_valid   = 1'b0;
        m_addr    = 0;
        m_data    = 1'b0;
        m_dl.delete();
        repeat (DELAY_STAGES) m_dl.push_back('0);
    endtask

    task automatic model_edge();
        bit free;
        free = !m_valid || ready;
        if (free) begin
            m_valid = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (m_sampled[i] != m_sent[i]) begin
                    m_valid   = 1'b1;
                    m_addr    = i;
                    m_data    = m_sampled[i];
                    m_sent[i] = m_sampled[i];
                    break;
                end
            end
        end
        m_dl.push_back(in_r);
        m_sampled = m_dl.pop_front();
    endtask

    task automatic check_all();
        chk("valid", 64'(msg_valid), 64'(m_valid));
        chk("pending", 64'(pending), 64'(m_sampled != m_sent));
        if (m_valid) begin
            chk("address", msg_address, 64'(m_addr));
            chk("data", msg_data, 64'(m_data));
            chk("action", 64'(msg_action), 64'(ACTION_INTERRUPT));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_valid", 64'(msg_valid), 64'd0);
        chk("reset_pending", 64'(pending), 64'd0);
        chk("reset_address", msg_address, 64'd0);
        chk("reset_data", msg_data, 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int k;

        // Quiet inputs after reset: nothing to report.
        in_r = 4'b0000;
        ready = 1'b1;
        do_reset();
        repeat (10) step();

        // High inputs at release are reported in ascending order, back-to-back.
        in_r = 4'b1010;
        do_reset();
        k = 0;
        while (!msg_valid && k < 8) begin
            step();
            k++;
        end
        chk("first_addr", msg_address, 64'd1);
        chk("first_data", msg_data, 64'd1);
        step();
        chk("second_addr", msg_address, 64'd3);
        chk("second_data", msg_data, 64'd1);
        step();
        chk("drain_valid", 64'(msg_valid), 64'd0);
        repeat (2) step();

        // Back-pressure holds the message stable, then exactly one transfer.
        ready = 1'b0;
        in_r[2] = 1'b1;
        repeat (8) step();
        chk("held_addr", msg_address, 64'd2);
        ready = 1'b1;
        repeat (3) step();

        // Input 0 toggles while its message is blocked; a short pulse on input 3 is coalesced away.
        ready = 1'b0;
        in_r[0] = 1'b1;
        repeat (4) step();
        in_r[0] = 1'b0;
        step();
        in_r[3] = ~in_r[3];
        step();
        in_r[3] = ~in_r[3];
        repeat (4) step();
        ready = 1'b1;
        repeat (5) step();

        // Asynchronous reset while a message is on the wire.
        ready = 1'b0;
        in_r[1] = ~in_r[1];
        repeat (6) step();
        chk("pre_reset_valid", 64'(msg_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset_valid", 64'(msg_valid), 64'd0);
        chk("async_reset_pending", 64'(pending), 64'd0);
        in_r = '0;
        ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) step();

        // Latency from an input change to msg_valid, counted in edges.
        in_r[0] = 1'b1;
        k = 0;
        while (!msg_valid && k < 10) begin
            step();
            k++;
        end
        chk("latency_edges", 64'(k), 64'(2 + DELAY_STAGES));
        repeat (3) step();

        // Random traffic and random back-pressure.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) in_r[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) in_r = N'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            step();
        end
        ready = 1'b1;
        repeat (10) step();
        chk("final_pending", 64'(pending), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
